pauli_frame_scheduler: RTL

Sequencing controller in front of the BRAM Pauli frame tracker. It arbitrates between two requesters: decoder correction updates and measurement-readout queries. It turns each correction into a read-modify-write (XOR of Pauli) on the tracker and returns frame values for queries. It honours the tracker's read timing: the read address must be held, and data is valid 2 cycles after the read enable. Exactly one tracker operation is in flight at any time, so RAW hazards are impossible.

---
 rtl/pauli_frame_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pauli_frame_scheduler.sv
// Sequencer in front of the BRAM Pauli frame tracker: arbitrates corrections and
// measurement queries and runs exactly one read(-modify-write) on the tracker at a time.
module pauli_frame_scheduler #(
  parameter int NUM_QUBITS = 49,
  parameter int ADDR_W     = $clog2(NUM_QUBITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              corr_valid,
  output logic              corr_ready,
  input  logic [ADDR_W-1:0] corr_addr,
  input  logic [1:0]        corr_pauli,
  input  logic              meas_valid,
  output logic              meas_ready,
  input  logic [ADDR_W-1:0] meas_addr,
  output logic              meas_rsp_valid,
  output logic [ADDR_W-1:0] meas_rsp_addr,
  output logic [1:0]        meas_rsp_pauli,
  output logic              trk_wr_en,
  output logic [ADDR_W-1:0] trk_wr_addr,
  output logic [1:0]        trk_wr_pauli,
  output logic              trk_rd_en,
  output logic [ADDR_W-1:0] trk_rd_addr,
  input  logic [1:0]        trk_rd_pauli,
  input  logic              trk_rd_valid,
  output logic              busy,
  output logic              err_addr,
  output logic              err_proto,
  output logic [15:0]       stat_stall_cnt
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, WR} state_e;

  localparam logic [ADDR_W:0] NQ = (ADDR_W+1)'(NUM_QUBITS);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;          // 0: corr wins a contested grant, 1: meas
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pauli_q, pauli_d;
  logic [1:0]        cap_q, cap_d;
  logic              is_meas_q, is_meas_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]        rsp_pauli_q, rsp_pauli_d;
  logic              err_addr_q, err_addr_d;
  logic              err_proto_q, err_proto_d;
  logic [15:0]       stall_q, stall_d;

  logic              grant_corr, grant_meas;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_oob;
  logic [1:0]        rd_val;

  // Grants only in IDLE and not while a response is on the bus, so the next
  // accept lands the cycle after a response, just as it does after a write.
  always_comb begin
    grant_corr = 1'b0;
    grant_meas = 1'b0;
    if (rst_n && state_q == IDLE && !rsp_valid_q) begin
      if (corr_valid && meas_valid) begin
        if (corr_addr == meas_addr || !ptr_q) grant_corr = 1'b1;
        else                                  grant_meas = 1'b1;
      end else begin
        grant_corr = corr_valid;
        grant_meas = meas_valid;
      end
    end
  end

  assign acc_addr = grant_meas ? meas_addr : corr_addr;
  assign acc_oob  = {1'b0, acc_addr} >= NQ;
  assign rd_val   = trk_rd_valid ? trk_rd_pauli : 2'b00;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    pauli_d     = pauli_q;
    cap_d       = cap_q;
    is_meas_d   = is_meas_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = '0;
    rsp_pauli_d = 2'b00;
    err_addr_d  = err_addr_q;
    err_proto_d = err_proto_q;
    stall_d     = stall_q;

    if ((corr_valid || meas_valid) && !(grant_corr || grant_meas) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (grant_corr || grant_meas) begin
          addr_d    = acc_addr;
          pauli_d   = grant_meas ? 2'b00 : corr_pauli;
          is_meas_d = grant_meas;
          ptr_d     = grant_corr;
          if (acc_oob) begin
            err_addr_d = 1'b1;
            if (grant_meas) begin
              rsp_valid_d = 1'b1;
              rsp_addr_d  = acc_addr;
            end
          end else if (!(grant_corr && corr_pauli == 2'b00)) begin
            state_d = RD0;
          end
        end
      end
      RD0: state_d = RD1;
      RD1: state_d = CAP;
      CAP: begin
        if (!trk_rd_valid) err_proto_d = 1'b1;
        if (is_meas_q) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_pauli_d = rd_val;
          state_d     = IDLE;
        end else begin
          cap_d   = rd_val;
          state_d = WR;
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      addr_q      <= '0;
      pauli_q     <= 2'b00;
      cap_q       <= 2'b00;
      is_meas_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_pauli_q <= 2'b00;
      err_addr_q  <= 1'b0;
      err_proto_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      pauli_q     <= pauli_d;
      cap_q       <= cap_d;
      is_meas_q   <= is_meas_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_pauli_q <= rsp_pauli_d;
      err_addr_q  <= err_addr_d;
      err_proto_q <= err_proto_d;
      stall_q     <= stall_d;
    end
  end

  assign corr_ready     = grant_corr;
  assign meas_ready     = grant_meas;
  assign meas_rsp_valid = rsp_valid_q;
  assign meas_rsp_addr  = rsp_addr_q;
  assign meas_rsp_pauli = rsp_pauli_q;
  // The tracker needs the read address stable from RD0 through capture.
  assign trk_rd_en      = (state_q == RD0);
  assign trk_rd_addr    = (state_q == RD0 || state_q == RD1 || state_q == CAP) ? addr_q : '0;
  assign trk_wr_en      = (state_q == WR);
  assign trk_wr_addr    = (state_q == WR) ? addr_q : '0;
  assign trk_wr_pauli   = (state_q == WR) ? (cap_q ^ pauli_q) : 2'b00;
  assign busy           = (state_q != IDLE);
  assign err_addr       = err_addr_q;
  assign err_proto      = err_proto_q;
  assign stat_stall_cnt = stall_q;

endmodule
